// File: rtl/data_sram_bridge.sv
// data_sram_bridge: multi-cycle bridge from the MEM-stage data port to a data
// SRAM with configurable read latency. It places store data in the correct
// byte lanes, extracts and extends load data, flags misaligned accesses and
// stalls the pipeline until each access completes.
module data_sram_bridge #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [1:0]        cpu_size,
    input  logic              cpu_sign,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              cpu_done,
    output logic              cpu_adel,
    output logic              cpu_ades,
    output logic [31:0]       stall_cnt,
    output logic              sram_en,
    output logic [DATA_W/8-1:0] sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam int LN    = DATA_W / 8;
    localparam int LB    = $clog2(LN);
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

    state_t              state, state_nxt;
    logic                req_wr;
    logic [1:0]          req_size;
    logic                req_sign;
    logic [ADDR_W-1:0]   req_addr;
    logic                req_err;
    logic [CNT_W-1:0]    cnt;

    logic                issue;
    logic                misalign;
    logic                capture;
    logic [LN-1:0]       store_wen;
    logic [DATA_W-1:0]   store_wdata;
    logic [LB-1:0]       ext_lane;
    logic [1:0]          ext_size;
    logic                ext_sign;

    // Alignment rule per access size; doublewords need a 64-bit data path.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] lo);
        logic bad;
        case (size)
            2'd0:    bad = 1'b0;
            2'd1:    bad = lo[0];
            2'd2:    bad = |lo[1:0];
            default: bad = (DATA_W != 64) || (|lo);
        endcase
        return bad;
    endfunction

    // Pick the sized field starting at the lane and sign/zero-extend it.
    function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] d,
                                                  input logic [LB-1:0]     lane,
                                                  input logic [1:0]        size,
                                                  input logic              sgn);
        logic [DATA_W-1:0] sh;
        logic [DATA_W-1:0] res;
        sh = d >> {lane, 3'b000};
        case (size)
            2'd0:    if (sgn) res = DATA_W'($signed(sh[7:0]));  else res = DATA_W'(sh[7:0]);
            2'd1:    if (sgn) res = DATA_W'($signed(sh[15:0])); else res = DATA_W'(sh[15:0]);
            2'd2:    if (sgn) res = DATA_W'($signed(sh[31:0])); else res = DATA_W'(sh[31:0]);
            default: res = sh;
        endcase
        return res;
    endfunction

    // Reset is folded into issue so an asserted reset silences the SRAM port at once.
    assign misalign = is_misaligned(cpu_size, cpu_addr[2:0]);
    assign issue    = (state == IDLE) && cpu_req && !rst;

    // Loads issued with single-cycle latency extract from the live request,
    // longer reads extract from the latched copy.
    assign ext_lane = (state == IDLE) ? cpu_addr[LB-1:0] : req_addr[LB-1:0];
    assign ext_size = (state == IDLE) ? cpu_size : req_size;
    assign ext_sign = (state == IDLE) ? cpu_sign : req_sign;
    assign capture  = (issue && !cpu_wr && !misalign && (RD_LATENCY == 1)) ||
                      ((state == RD_WAIT) && (cnt == CNT_W'(1)));

    // Byte-lane enables and replicated write data for the current store.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
        store_wen   = '0;
        store_wdata = cpu_wdata;
        case (cpu_size)
            2'd0: begin
                store_wen   = LN'(1) << cpu_addr[LB-1:0];
                store_wdata = {LN{cpu_wdata[7:0]}};
            end
            2'd1: begin
                store_wen   = LN'(3) << cpu_addr[LB-1:0];
                store_wdata = {(DATA_W/16){cpu_wdata[15:0]}};
            end
            2'd2: begin
                store_wen   = LN'(15) << cpu_addr[LB-1:0];
                store_wdata = {(DATA_W/32){cpu_wdata[31:0]}};
            end
            default: begin
                store_wen   = '1;
                store_wdata = cpu_wdata;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (issue) begin
                    if (misalign || cpu_wr || (RD_LATENCY == 1)) state_nxt = RESP;
                    else                                         state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: if (cnt == CNT_W'(1)) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: SRAM strobes, stall, and the one-cycle completion response.
    always_comb begin
        cpu_stall  = 1'b0;
        cpu_done   = 1'b0;
        cpu_adel   = 1'b0;
        cpu_ades   = 1'b0;
        sram_en    = 1'b0;
        sram_wen   = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        case (state)
            IDLE: begin
                if (issue) begin
                    cpu_stall = 1'b1;
                    if (!misalign) begin
                        sram_en   = 1'b1;
                        sram_addr = cpu_addr;
                        if (cpu_wr) begin
                            sram_wen   = store_wen;
                            sram_wdata = store_wdata;
                        end
                    end
                end
            end
            RD_WAIT: begin
                cpu_stall = 1'b1;
                sram_en   = 1'b1;
                sram_addr = req_addr;
            end
            RESP: begin
                cpu_done = 1'b1;
                cpu_adel = req_err && !req_wr;
                cpu_ades = req_err && req_wr;
            end
            default: ;
        endcase
    end

    // Latch the request, run the read-latency counter and capture load data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the latched request is a handful of flops, not a memory array, so it is cleared on reset like any other state.
            req_wr    <= 1'b0;
            req_size  <= 2'd0;
            req_sign  <= 1'b0;
            req_addr  <= '0;
            req_err   <= 1'b0;
            cnt       <= '0;
            cpu_rdata <= '0;
        end else begin
            if (issue) begin
                req_wr   <= cpu_wr;
                req_size <= cpu_size;
                req_sign <= cpu_sign;
                req_addr <= cpu_addr;
                req_err  <= misalign;
                cnt      <= CNT_W'(RD_LATENCY - 1);
            end else if (state == RD_WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (capture) begin
                cpu_rdata <= extract(sram_rdata, ext_lane, ext_size, ext_sign);
            end
        end
    end

    // Saturating count of stalled cycles for performance debug.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (cpu_stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule
